// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS subset core.
//   Steps: FETCH -> DECODE -> EXEC -> MEM -> WB. Each instruction leaves the
//   sequence early once its work is done.
//   Instruction fetch uses a combinational port. Data memory uses a req/ack
//   handshake, and each request is held stable until it is acknowledged.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_addr / imem_rdata       fetch address (= pc) / instruction word
//   dmem_req/we/addr/wdata       data request, held while in MEM
//   dmem_rdata / dmem_ack        load data / one-cycle completion
//   pc                           current program counter
//   retire, overflow, illegal    one-cycle status pulses per instruction
module mips_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          OV_REG   = 30,
    parameter int          LINK_REG = 31,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] pc,
    output logic        retire,
    output logic        overflow,
    output logic        illegal
);
    localparam int         RW  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0] NR6 = 6'(NREGS);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    state_t state, state_next;

    logic [31:0] ir, pc4, a, b, alu_out, mdr;
    logic [31:0] gpr [NREGS];

    logic [31:0] pc_next;
    logic        retire_next, overflow_next, illegal_next;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;

    // Instruction fields
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] simm;
    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign imm   = ir[15:0];
    assign funct = ir[5:0];
    assign simm  = {{16{imm[15]}}, imm};

    logic is_r, op_addu, op_subu, op_slt, op_jr, op_addi, op_ori, op_lui;
    logic op_lw, op_sw, op_beq, op_j, op_jal, op_legal;
    assign is_r     = (op == 6'h00);
    assign op_addu  = is_r && (funct == 6'h21);
    assign op_subu  = is_r && (funct == 6'h23);
    assign op_slt   = is_r && (funct == 6'h2A);
    assign op_jr    = is_r && (funct == 6'h08);
    assign op_addi  = (op == 6'h08);
    assign op_ori   = (op == 6'h0D);
    assign op_lui   = (op == 6'h0F);
    assign op_lw    = (op == 6'h23);
    assign op_sw    = (op == 6'h2B);
    assign op_beq   = (op == 6'h04);
    assign op_j     = (op == 6'h02);
    assign op_jal   = (op == 6'h03);
    assign op_legal = op_addu | op_subu | op_slt | op_jr | op_addi | op_ori |
                      op_lui | op_lw | op_sw | op_beq | op_j | op_jal;

    // Register file read: $0 and indices beyond NREGS read as zero
    logic [31:0] rs_val, rt_val;
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0 && {1'b0, rs} < NR6) rs_val = gpr[rs[RW-1:0]];
        if (rt != 5'd0 && {1'b0, rt} < NR6) rt_val = gpr[rt[RW-1:0]];
    end

    // ALU; lw/sw/addi share the rs + sext(imm) adder
    logic [31:0] alu_res, sum_imm;
    assign sum_imm = a + simm;
    always_comb begin
        alu_res = sum_imm;
        if (op_addu)      alu_res = a + b;
        else if (op_subu) alu_res = a - b;
        else if (op_slt)  alu_res = {31'd0, $signed(a) < $signed(b)};
        else if (op_ori)  alu_res = a | {16'd0, imm};
        else if (op_lui)  alu_res = {imm, 16'd0};
    end

    // Signed overflow of addi, evaluated in WB from the held operand and sum
    logic addi_ov;
    assign addi_ov = op_addi && (a[31] == simm[31]) && (alu_out[31] != a[31]);

    logic [31:0] br_target, j_target;
    assign br_target = pc4 + (simm << 2);
    assign j_target  = {pc4[31:28], ir[25:0], 2'b00};

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        retire_next   = 1'b0;
        overflow_next = 1'b0;
        illegal_next  = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = 5'd0;
        wr_data       = '0;
        case (state)
            FETCH: state_next = DECODE;
            DECODE: begin
                if (!op_legal) begin
                    pc_next      = pc4;
                    retire_next  = 1'b1;
                    illegal_next = 1'b1;
                    state_next   = FETCH;
                end else if (op_j || op_jal) begin
                    pc_next     = j_target;
                    retire_next = 1'b1;
                    state_next  = FETCH;
                    if (op_jal) begin
                        wr_en   = 1'b1;
                        wr_idx  = 5'(LINK_REG);
                        wr_data = pc4;
                    end
                end else if (op_jr) begin
                    pc_next     = rs_val;
                    retire_next = 1'b1;
                    state_next  = FETCH;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (op_beq) begin
                    pc_next     = (a == b) ? br_target : pc4;
                    retire_next = 1'b1;
                    state_next  = FETCH;
                end else if (op_lw || op_sw) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    if (op_sw) begin
                        pc_next     = pc4;
                        retire_next = 1'b1;
                        state_next  = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                wr_en       = 1'b1;
                pc_next     = pc4;
                retire_next = 1'b1;
                state_next  = FETCH;
                if (addi_ov) begin
                    // Trap: destination untouched, flag register set instead
                    wr_idx        = 5'(OV_REG);
                    wr_data       = 32'd1;
                    overflow_next = 1'b1;
                end else begin
                    wr_idx  = is_r ? rd : rt;
                    wr_data = op_lw ? mdr : alu_out;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    logic wr_ok;
    assign wr_ok = wr_en && (wr_idx != 5'd0) && ({1'b0, wr_idx} < NR6);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            pc4      <= '0;
            a        <= '0;
            b        <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            retire   <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            retire   <= retire_next;
            overflow <= overflow_next;
            illegal  <= illegal_next;
            if (state == FETCH) begin
                ir  <= imem_rdata;
                pc4 <= pc + 32'd4;
            end
            if (state == DECODE) begin
                a <= rs_val;
                b <= rt_val;
            end
            if (state == EXEC) alu_out <= alu_res;
            if (state == MEM && dmem_ack && op_lw) mdr <= dmem_rdata;
            if (wr_ok) gpr[wr_idx[RW-1:0]] <= wr_data;
        end
    end

    assign imem_addr  = pc;
    assign dmem_req   = (state == MEM);
    assign dmem_we    = (state == MEM) && op_sw;
    assign dmem_addr  = alu_out;
    assign dmem_wdata = b;
endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: instruction-level reference model plus a variable-latency
// memory responder. Each instruction is placed at the model's PC, and then
// the bench checks the cycle count, the retire flags, the resulting PC and
// any memory access.
module tb_mips_mc_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] pc;
    logic        retire, overflow, illegal;

    int checks = 0;
    int errors = 0;

    // Single-word instruction memory: only the model's current PC holds code
    logic [31:0] cur_addr  = 32'h0;
    logic [31:0] cur_instr = 32'h0;
    assign imem_rdata = (imem_addr == cur_addr) ? cur_instr : 32'h0;

    mips_mc_core dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc(pc), .retire(retire), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    logic [31:0] tb_mem [logic [29:0]];
    int          ack_delay = 1;   // 0 = never acknowledge
    bit          stray_ack = 1'b0;
    int          req_cnt   = 0;
    int          ack_cnt   = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    initial begin
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (stray_ack) begin
                dmem_ack = 1'b1;
                req_cnt  = 0;
            end else if (dmem_req === 1'b1) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    cap_addr  = dmem_addr;
                    cap_wdata = dmem_wdata;
                    cap_we    = dmem_we;
                end else begin
                    checks++;
                    if (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata || dmem_we !== cap_we) begin
                        errors++;
                        $display("FAIL mem_stable: got addr %h data %h we %b, held %h %h %b",
                                 dmem_addr, dmem_wdata, dmem_we, cap_addr, cap_wdata, cap_we);
                    end
                end
                if (ack_delay != 0 && req_cnt == ack_delay) begin
                    dmem_ack = 1'b1;
                    ack_cnt++;
                    if (dmem_we) tb_mem[dmem_addr[31:2]] = dmem_wdata;
                    else dmem_rdata = tb_mem.exists(dmem_addr[31:2]) ? tb_mem[dmem_addr[31:2]] : 32'h0;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_regs [32];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] ref_pc;

    task automatic ref_reset();
        ref_pc = 32'h0000_3000;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    endtask

    task automatic ref_wr(input int r, input logic [31:0] v);
        if (r != 0) ref_regs[r] = v;
    endtask

    task automatic model_step(input logic [31:0] ins, input int n, output int cyc,
                              output bit ov, output bit ill, output bit is_mem,
                              output bit mwe, output logic [31:0] maddr,
                              output logic [31:0] mwd);
        int          rs, rt, rd;
        logic [5:0]  op, fn;
        logic [31:0] a, b, simm, pc4, npc;
        longint      s;
        op = ins[31:26]; fn = ins[5:0];
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        a = ref_regs[rs]; b = ref_regs[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        pc4 = ref_pc + 32'd4; npc = pc4;
        cyc = 4; ov = 0; ill = 0; is_mem = 0; mwe = 0; maddr = 0; mwd = 0;
        case (op)
            6'h00: case (fn)
                6'h21: ref_wr(rd, a + b);
                6'h23: ref_wr(rd, a - b);
                6'h2A: ref_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                6'h08: begin npc = a; cyc = 2; end
                default: begin ill = 1; cyc = 2; end
            endcase
            6'h08: begin
                s = longint'($signed(a)) + longint'($signed(simm));
                if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
                    ov = 1;
                    ref_wr(30, 32'd1);
                end else ref_wr(rt, a + simm);
            end
            6'h0D: ref_wr(rt, a | {16'h0, ins[15:0]});
            6'h0F: ref_wr(rt, {ins[15:0], 16'h0});
            6'h23: begin
                is_mem = 1; maddr = a + simm; cyc = 4 + n;
                ref_wr(rt, ref_mem.exists(maddr[31:2]) ? ref_mem[maddr[31:2]] : 32'h0);
            end
            6'h2B: begin
                is_mem = 1; mwe = 1; maddr = a + simm; mwd = b; cyc = 3 + n;
                ref_mem[maddr[31:2]] = b;
            end
            6'h04: begin
                cyc = 3;
                if (a == b) npc = pc4 + simm * 32'd4;
            end
            6'h02, 6'h03: begin
                cyc = 2;
                npc = {pc4[31:28], ins[25:0], 2'b00};
                if (op == 6'h03) ref_wr(31, pc4);
            end
            default: begin ill = 1; cyc = 2; end
        endcase
        ref_pc = npc;
    endtask

    function automatic logic [31:0] r_ins(input int f, input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(f)};
    endfunction
    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] j_ins(input int op, input logic [31:0] target);
        return {6'(op), target[27:2]};
    endfunction

    // Runs one instruction from its FETCH cycle to its retire pulse.
    task automatic exec_one(input logic [31:0] ins, input int n);
        int          cyc, cnt, acks0;
        bit          e_ov, e_ill, e_mem, e_we, got;
        logic [31:0] e_addr, e_wd, at;
        at = ref_pc;
        cur_addr = ref_pc; cur_instr = ins; ack_delay = n; acks0 = ack_cnt;
        model_step(ins, n, cyc, e_ov, e_ill, e_mem, e_we, e_addr, e_wd);
        cnt = 0; got = 0;
        while (!got && cnt < 64) begin
            @(posedge clk); cnt++;
            @(negedge clk);
            if (retire === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL retire_timeout: instr %h at %h got no retire, required one within 64 cycles", ins, at);
        end else begin
            checks++;
            if (cnt != cyc) begin errors++; $display("FAIL cycles: instr %h got %0d required %0d", ins, cnt, cyc); end
            checks++;
            if (pc !== ref_pc) begin errors++; $display("FAIL next_pc: instr %h got %h required %h", ins, pc, ref_pc); end
            checks++;
            if (overflow !== e_ov) begin errors++; $display("FAIL overflow: instr %h got %b required %b", ins, overflow, e_ov); end
            checks++;
            if (illegal !== e_ill) begin errors++; $display("FAIL illegal: instr %h got %b required %b", ins, illegal, e_ill); end
            if (e_mem) begin
                checks++;
                if (ack_cnt != acks0 + 1) begin errors++; $display("FAIL mem_acks: instr %h got %0d required 1", ins, ack_cnt - acks0); end
                checks++;
                if (cap_we !== e_we || cap_addr !== e_addr) begin
                    errors++; $display("FAIL mem_addr: instr %h got %h we %b required %h we %b", ins, cap_addr, cap_we, e_addr, e_we);
                end
                if (e_we) begin
                    checks++;
                    if (cap_wdata !== e_wd) begin errors++; $display("FAIL store_data: instr %h got %h required %h", ins, cap_wdata, e_wd); end
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc: got %h required 00003000", pc); end
        checks++;
        if (dmem_req !== 1'b0 || retire !== 1'b0 || overflow !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got req %b ret %b ov %b ill %b required all 0", dmem_req, retire, overflow, illegal);
        end
        rst = 1'b0;
        ref_reset();
        exec_one(i_ins(6'h0D, 0, 1, 16'h1234), 1);
        exec_one(i_ins(6'h2B, 0, 1, 32'h100), 1);
        checks++;
        if (cap_wdata !== 32'h0000_1234) begin errors++; $display("FAIL ori_value: got %h required 00001234", cap_wdata); end
    endtask

    task automatic test_alu();
        exec_one(i_ins(6'h0F, 0, 2, 16'h8000), 1);
        exec_one(r_ins(6'h21, 2, 1, 7), 1);
        exec_one(r_ins(6'h23, 1, 2, 8), 1);
        exec_one(r_ins(6'h2A, 2, 1, 3), 1);
        exec_one(r_ins(6'h2A, 1, 2, 10), 1);
        exec_one(i_ins(6'h2B, 0, 8, 32'h104), 2);
        checks++;
        if (cap_wdata !== 32'h8000_1234) begin errors++; $display("FAIL subu_wrap: got %h required 80001234", cap_wdata); end
        exec_one(i_ins(6'h2B, 0, 3, 32'h108), 1);
        checks++;
        if (cap_wdata !== 32'h1) begin errors++; $display("FAIL slt_signed: got %h required 00000001", cap_wdata); end
    endtask

    task automatic test_addi_ov();
        exec_one(i_ins(6'h0F, 0, 4, 16'h7FFF), 1);
        exec_one(i_ins(6'h0D, 4, 4, 16'hFFFF), 1);
        exec_one(i_ins(6'h08, 4, 5, 1), 1);
        exec_one(i_ins(6'h2B, 0, 30, 32'h10C), 1);
        checks++;
        if (cap_wdata !== 32'h1) begin errors++; $display("FAIL ov_reg: got %h required 00000001", cap_wdata); end
        exec_one(i_ins(6'h2B, 0, 5, 32'h110), 1);
        checks++;
        if (cap_wdata !== 32'h0) begin errors++; $display("FAIL ov_dest: got %h required 00000000", cap_wdata); end
        exec_one(i_ins(6'h08, 4, 5, -1), 1);
        exec_one(i_ins(6'h2B, 0, 5, 32'h114), 1);
        checks++;
        if (cap_wdata !== 32'h7FFF_FFFE) begin errors++; $display("FAIL addi_value: got %h required 7ffffffe", cap_wdata); end
        exec_one(i_ins(6'h0F, 0, 11, 16'h8000), 1);
        exec_one(i_ins(6'h08, 11, 12, -1), 1);
    endtask

    task automatic test_mem();
        exec_one(i_ins(6'h2B, 0, 1, 4), 3);
        checks++;
        if (cap_addr !== 32'h4 || cap_wdata !== 32'h1234) begin
            errors++; $display("FAIL sw_access: got %h/%h required 00000004/00001234", cap_addr, cap_wdata);
        end
        exec_one(i_ins(6'h23, 0, 6, 4), 1);
        exec_one(i_ins(6'h2B, 0, 6, 32'h118), 1);
        checks++;
        if (cap_wdata !== 32'h1234) begin errors++; $display("FAIL lw_value: got %h required 00001234", cap_wdata); end
    endtask

    task automatic test_ctrl();
        logic [31:0] at;
        at = ref_pc;
        exec_one(i_ins(6'h04, 0, 0, -1), 1);
        checks++;
        if (pc !== at) begin errors++; $display("FAIL beq_self: got %h required %h", pc, at); end
        exec_one(i_ins(6'h04, 1, 0, 5), 1);
        checks++;
        if (pc !== at + 32'd4) begin errors++; $display("FAIL beq_not_taken: got %h required %h", pc, at + 32'd4); end
        exec_one(j_ins(6'h02, 32'h3010), 1);
        exec_one(j_ins(6'h03, 32'h3200), 1);
        exec_one(i_ins(6'h2B, 0, 31, 32'h11C), 1);
        checks++;
        if (cap_wdata !== 32'h3014) begin errors++; $display("FAIL jal_link: got %h required 00003014", cap_wdata); end
        exec_one(r_ins(6'h08, 31, 0, 0), 1);
        checks++;
        if (pc !== 32'h3014) begin errors++; $display("FAIL jr_return: got %h required 00003014", pc); end
        exec_one(i_ins(6'h08, 0, 0, 5), 1);
        exec_one(i_ins(6'h2B, 0, 0, 32'h120), 1);
        checks++;
        if (cap_wdata !== 32'h0) begin errors++; $display("FAIL r0_write: got %h required 00000000", cap_wdata); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        cur_addr = ref_pc; cur_instr = i_ins(6'h2B, 0, 1, 32'h180); ack_delay = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (dmem_req === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL req_start: got no dmem_req, required one within 16 cycles"); end
        repeat (3) @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin errors++; $display("FAIL req_held: got %b required 1", dmem_req); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || pc !== 32'h3000) begin
            errors++; $display("FAIL reset_mid: got req %b pc %h required 0 00003000", dmem_req, pc);
        end
        rst = 1'b0;
        stray_ack = 1'b1;
        ref_reset();
        exec_one(32'hFC00_0000, 1);
        stray_ack = 1'b0;
        checks++;
        if (pc !== 32'h3004) begin errors++; $display("FAIL illegal_pc: got %h required 00003004", pc); end
        exec_one(i_ins(6'h2B, 0, 1, 32'h184), 2);
        checks++;
        if (cap_wdata !== 32'h0) begin errors++; $display("FAIL gpr_reset: got %h required 00000000", cap_wdata); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            int          kind, rs, rt, rd, n, imm;
            logic [31:0] ins;
            kind = $urandom_range(0, 11);
            rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
            n = $urandom_range(1, 4);
            imm = $urandom_range(0, 65535);
            case (kind)
                0:  ins = r_ins(6'h21, rs, rt, rd);
                1:  ins = r_ins(6'h23, rs, rt, rd);
                2:  ins = r_ins(6'h2A, rs, rt, rd);
                3:  ins = i_ins(6'h0D, rs, rt, imm);
                4:  ins = i_ins(6'h0F, 0, rt, imm);
                5:  ins = i_ins(6'h08, rs, rt, imm);
                6:  ins = i_ins(6'h2B, 0, rt, 32'h200 + 4 * $urandom_range(0, 15));
                7:  ins = i_ins(6'h23, 0, rt, 32'h200 + 4 * $urandom_range(0, 15));
                8:  ins = i_ins(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, $urandom_range(0, 8) - 4);
                9:  ins = j_ins($urandom_range(2, 3), 32'h3000 + 4 * $urandom_range(0, 511));
                10: ins = r_ins(6'h08, rs, 0, 0);
                default: ins = ($urandom_range(0, 1) == 1) ? 32'hFC00_0000 : r_ins(6'h3F, rs, rt, rd);
            endcase
            exec_one(ins, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_addi_ov();
        test_mem();
        test_ctrl();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
- Multi-cycle, parametrised successor to the team's single-cycle MIPS datapath.
- Fetch/decode/execute sequencing is internal, through a step FSM and an internal decoder.
- Instruction fetch uses a combinational instruction-memory port.
- Data memory is reached over a variable-latency req/ack handshake, so the core can sit in front of slow or shared memory.
- Adds an addi overflow trap (write 1 to OV_REG), jr/jal/slt, retire/illegal status pulses, and a configurable reset PC.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- OV_REG, 30, GPR index written with 1 when addi overflows.
- LINK_REG, 31, GPR index written by jal.
- NREGS, 32, GPR count; power of 2, at most 32. Register indices at or above NREGS read 0 and writes to them are dropped.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address of the current fetch; equals pc.
- imem_rdata  in  32  instruction word, combinational from imem_addr.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load; valid while dmem_req.
- dmem_addr  out  32  byte address (ALU result); bits [1:0] ignored by memory.
- dmem_wdata  out  32  store data (rt value).
- dmem_rdata  in  32  load data; valid in the dmem_ack cycle.
- dmem_ack  in  1  one-cycle completion of the request.
- pc  out  32  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- overflow  out  1  one-cycle pulse with retire of an overflowing addi.
- illegal  out  1  one-cycle pulse with retire of an undecoded instruction.

Behaviour:
- Reset values (synchronous, so they take effect at the clock edge with rst=1):
  - state=FETCH, pc=RESET_PC, all GPRs=0.
  - dmem_req=0, dmem_we=0, retire=0, overflow=0, illegal=0.
- Reset mid-operation: rst wins over every transition. An outstanding dmem_req drops at that edge and any later dmem_ack is ignored.
- FSM states: FETCH, DECODE, EXEC, MEM, WB.
- FETCH: IR <= imem_rdata; PC4 <= pc+4 (32-bit wrap); go to DECODE.
- DECODE: A <= GPR[rs], B <= GPR[rt].
  - j: pc <= {PC4[31:28], IR[25:0], 2'b00}; retire; go to FETCH.
  - jal: same as j, plus GPR[LINK_REG] <= PC4.
  - jr: pc <= GPR[rs]; retire.
  - Illegal opcode/funct: pc <= PC4; illegal+retire; no state change otherwise.
  - All other instructions go to EXEC.
- EXEC: ALUOut <= result.
  - beq: if A==B, pc <= PC4 + (sext(imm)<<2), else pc <= PC4; retire; go to FETCH.
  - lw/sw: ALUOut = A + sext(imm); go to MEM.
  - Everything else goes to WB.
- MEM: dmem_req=1, with dmem_we, dmem_addr=ALUOut and dmem_wdata=B, held stable until dmem_ack.
  - On ack, lw: MDR <= dmem_rdata; go to WB.
  - On ack, sw: pc <= PC4; retire; go to FETCH.
  - Ack in the same cycle as entry into MEM is legal; minimum MEM residency is 1 cycle.
  - dmem_ack outside MEM is ignored.
- WB: write the GPR, pc <= PC4, retire, go to FETCH.
- Cycle counts: j/jal/jr/illegal 2; beq 3; ALU ops 4; sw 3+n; lw 4+n, where n = MEM cycles up to and including ack (n>=1).
- Decoded ops:
  - addu (0/21h), subu (0/23h): wrapping, result to rd.
  - slt (0/2Ah): signed compare, 1/0 to rd.
  - ori: rt = rs | zext(imm).
  - lui: rt = imm<<16.
  - addi (08h): rt = rs + sext(imm) when there is no signed overflow.
  - addi with overflow (sign of A equals sign of imm and differs from sign of result): rt is NOT written, GPR[OV_REG] <= 1, overflow pulses with retire.
  - lw (23h), sw (2Bh), beq (04h), j (02h), jal (03h), jr (0/08h).
- GPR rules:
  - Register 0 reads 0 and ignores writes.
  - Reads happen in DECODE and are never bypassed; writes land at the end of WB/DECODE, before the next FETCH.
- Retire timing: retire/overflow/illegal assert in the cycle after the completing state's edge, for exactly 1 cycle.

Test Plan:
- Reset: rst=1 for 2 cycles -> pc=3000h, dmem_req=0, retire=0. Then ori $1,$0,0x1234 -> retire after 4 cycles, $1=0000_1234.
- ALU ops: lui $2,0x8000; addu/subu/slt on $2,$1 -> subu wraps; slt $3,$2,$1 gives 1 (signed).
- addi overflow: $4=7FFF_FFFF; addi $5,$4,1 -> $5 unchanged, $30=1, overflow pulse. addi $5,$4,-1 -> $5=7FFF_FFFE, $30 untouched.
- Memory handshake: sw $1,4($0) with ack delayed 3 cycles -> dmem_req/addr/wdata stable 3 cycles, addr=4, data=1234h. Then lw $6,4($0) with same-cycle ack -> $6=1234h, 5 cycles total.
- Control flow:
  - beq taken with imm=-1 -> pc = own address.
  - beq not taken -> pc+4.
  - jal at 3010h -> $31=3014h, then jr $31 returns to 3014h.
  - Write to $0 -> $0 reads 0.
- Reset during MEM (ack withheld) -> dmem_req=0 after that edge; late ack ignored; pc=3000h; illegal opcode 3Fh -> illegal pulse, pc+4.
